// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle main controller driving ALU control plus PC/IR/memory/register-file
// enables for a multi-cycle datapath. Each instruction walks FETCH/DECODE/EXEC/MEM/WB states.
// All outputs except PCWrite are registered: they are computed from the next state and loaded
// together with it. PCWrite additionally ORs in the live ALU zero flag while in S_BR, so a taken
// branch loads the PC in the same cycle.
// Optional feature macro: OVF_TRAP_EN (addi signed-overflow trap). Undefined by default.
module mc_ctrl_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  output logic [2:0]         ALUOp,
  output logic               ALUSrc,
  output logic [1:0]         ext_op,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_FETCH = 4'd1,
    S_DECODE= 4'd2,
    S_EXR   = 4'd3,
    S_WBR   = 4'd4,
    S_EXI   = 4'd5,
    S_WBI   = 4'd6,
    S_MADDR = 4'd7,
    S_MRD   = 4'd8,
    S_MWB   = 4'd9,
    S_MWR   = 4'd10,
    S_BR    = 4'd11,
    S_JMP   = 4'd12,
    S_ILL   = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADDI = 3'b100;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  state_t     state_q, state_n;

  // Decoded-instruction context captured in S_DECODE so later states ignore IR changes
  logic       is_lw_q, is_lw_n;
  logic       is_addi_q, is_addi_n;
  logic       trap_q, trap_n;
  logic [2:0] alu_sel_q, alu_sel_n;
  logic [1:0] ext_sel_q, ext_sel_n;

  // Next values of the registered outputs
  logic [2:0] alu_op_n;
  logic       alu_src_n;
  logic [1:0] ext_op_n;
  logic       pc_write_n, pc_write_q;
  logic [1:0] pc_src_n;
  logic       ir_write_n, mem_read_n, mem_write_n;
  logic       reg_write_n, reg_dst_n, mem_to_reg_n;
  logic       done_n, illegal_n;

  // Next-state selection and instruction classification
  always_comb begin
    state_n   = state_q;
    is_lw_n   = is_lw_q;
    is_addi_n = is_addi_q;
    trap_n    = trap_q;
    alu_sel_n = alu_sel_q;
    ext_sel_n = ext_sel_q;
    case (state_q)
      S_RST:   state_n = S_FETCH;
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        is_lw_n   = 1'b0;
        is_addi_n = 1'b0;
        trap_n    = 1'b0;
        alu_sel_n = ALU_ADD;
        ext_sel_n = EXT_ZERO;
        case (opcode)
          6'b000000: begin
            case (funct)
              6'b100001: begin state_n = S_EXR; alu_sel_n = ALU_ADD; end
              6'b100011: begin state_n = S_EXR; alu_sel_n = ALU_SUB; end
              6'b101010: begin state_n = S_EXR; alu_sel_n = ALU_SLT; end
              default:   state_n = S_ILL;
            endcase
          end
          6'b001001: begin state_n = S_EXI; alu_sel_n = ALU_ADD; ext_sel_n = EXT_SIGN; end
          6'b001101: begin state_n = S_EXI; alu_sel_n = ALU_OR;  ext_sel_n = EXT_ZERO; end
          6'b001111: begin state_n = S_EXI; alu_sel_n = ALU_OR;  ext_sel_n = EXT_LUI;  end
          6'b001000: begin
            state_n   = S_EXI;
            alu_sel_n = ALU_ADDI;
            ext_sel_n = EXT_SIGN;
            is_addi_n = 1'b1;
          end
          6'b100011: begin state_n = S_MADDR; is_lw_n = 1'b1; end
          6'b101011: begin state_n = S_MADDR; is_lw_n = 1'b0; end
          6'b000100: state_n = S_BR;
          6'b000010: state_n = S_JMP;
          default:   state_n = S_ILL;
        endcase
      end
      S_EXR: state_n = S_WBR;
      S_WBR: state_n = S_FETCH;
      S_EXI: begin
        state_n = S_WBI;
`ifdef OVF_TRAP_EN
        trap_n  = is_addi_q & overflow;
`endif
      end
      S_WBI:   state_n = trap_q ? S_ILL : S_FETCH;
      S_MADDR: state_n = is_lw_q ? S_MRD : S_MWR;
      S_MRD:   state_n = S_MWB;
      S_MWB:   state_n = S_FETCH;
      S_MWR:   state_n = S_FETCH;
      S_BR:    state_n = S_FETCH;
      S_JMP:   state_n = S_FETCH;
      S_ILL:   state_n = S_FETCH;
      default: state_n = S_FETCH;
    endcase
  end

`ifndef OVF_TRAP_EN
  // Overflow only matters for the trap; keep it visibly consumed in the default build
  logic unused_ovf;
  assign unused_ovf = overflow ^ is_addi_q;
`endif

  // Moore output decode of the state being entered
  always_comb begin
    alu_op_n     = ALU_ADD;
    alu_src_n    = 1'b0;
    ext_op_n     = EXT_ZERO;
    pc_write_n   = 1'b0;
    pc_src_n     = 2'b00;
    ir_write_n   = 1'b0;
    mem_read_n   = 1'b0;
    mem_write_n  = 1'b0;
    reg_write_n  = 1'b0;
    reg_dst_n    = 1'b0;
    mem_to_reg_n = 1'b0;
    done_n       = 1'b0;
    illegal_n    = 1'b0;
    case (state_n)
      S_FETCH: begin
        mem_read_n = 1'b1;
        ir_write_n = 1'b1;
        pc_write_n = 1'b1;
        pc_src_n   = 2'b00;
      end
      S_EXR: begin
        alu_op_n  = alu_sel_n;
        alu_src_n = 1'b0;
      end
      S_WBR: begin
        reg_write_n = 1'b1;
        reg_dst_n   = 1'b1;
        done_n      = 1'b1;
      end
      S_EXI: begin
        alu_op_n  = alu_sel_n;
        alu_src_n = 1'b1;
        ext_op_n  = ext_sel_n;
      end
      S_WBI: begin
        reg_write_n = ~trap_n;
        done_n      = ~trap_n;
      end
      S_MADDR: begin
        alu_op_n  = ALU_ADD;
        alu_src_n = 1'b1;
        ext_op_n  = EXT_SIGN;
      end
      S_MRD: mem_read_n = 1'b1;
      S_MWB: begin
        reg_write_n  = 1'b1;
        mem_to_reg_n = 1'b1;
        done_n       = 1'b1;
      end
      S_MWR: begin
        mem_write_n = 1'b1;
        done_n      = 1'b1;
      end
      S_BR: begin
        alu_op_n = ALU_SUB;
        pc_src_n = 2'b01;
        done_n   = 1'b1;
      end
      S_JMP: begin
        pc_write_n = 1'b1;
        pc_src_n   = 2'b10;
        done_n     = 1'b1;
      end
      S_ILL: begin
        illegal_n = 1'b1;
        done_n    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, decoded context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      is_lw_q    <= 1'b0;
      is_addi_q  <= 1'b0;
      trap_q     <= 1'b0;
      alu_sel_q  <= ALU_ADD;
      ext_sel_q  <= EXT_ZERO;
      ALUOp      <= 3'b000;
      ALUSrc     <= 1'b0;
      ext_op     <= 2'b00;
      pc_write_q <= 1'b0;
      PCSrc      <= 2'b00;
      IRWrite    <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      RegDst     <= 1'b0;
      MemtoReg   <= 1'b0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_n;
      is_lw_q    <= is_lw_n;
      is_addi_q  <= is_addi_n;
      trap_q     <= trap_n;
      alu_sel_q  <= alu_sel_n;
      ext_sel_q  <= ext_sel_n;
      ALUOp      <= alu_op_n;
      ALUSrc     <= alu_src_n;
      ext_op     <= ext_op_n;
      pc_write_q <= pc_write_n;
      PCSrc      <= pc_src_n;
      IRWrite    <= ir_write_n;
      MemRead    <= mem_read_n;
      MemWrite   <= mem_write_n;
      RegWrite   <= reg_write_n;
      RegDst     <= reg_dst_n;
      MemtoReg   <= mem_to_reg_n;
      instr_done <= done_n;
      illegal    <= illegal_n;
    end
  end

  // Branch PC load follows the live zero flag during S_BR
  assign PCWrite = pc_write_q | ((state_q == S_BR) & zero);

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized self-checking bench for mc_ctrl_fsm. A per-instruction
// cycle-table model predicts every output on every cycle of each instruction.
// Honours OVF_TRAP_EN the same way as the design when defined at build time.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic [2:0] ALUOp;
  logic       ALUSrc;
  logic [1:0] ext_op;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
  logic       instr_done, illegal;
  logic [3:0] state;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .ext_op(ext_op), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Output bundle: ALUOp,ALUSrc,ext_op,PCWrite,PCSrc,IRWrite,MemRead,MemWrite,
  // RegWrite,RegDst,MemtoReg,instr_done,illegal
  logic [18:0] obs;
  assign obs = {ALUOp, ALUSrc, ext_op, PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
                RegWrite, RegDst, MemtoReg, instr_done, illegal};

  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_RBAD, K_ADDIU, K_ORI, K_LUI, K_ADDI,
                    K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  int errors = 0;
  int checks = 0;

`ifdef OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] pack(input logic [2:0] aop, input logic asrc,
      input logic [1:0] ext, input logic pcw, input logic [1:0] pcs, input logic irw,
      input logic mr, input logic mw, input logic rw, input logic rd, input logic m2r,
      input logic dn, input logic il);
    return {aop, asrc, ext, pcw, pcs, irw, mr, mw, rw, rd, m2r, dn, il};
  endfunction

  // Instruction length in cycles including FETCH
  function automatic int instr_len(input kind_t k, input bit trap);
    case (k)
      K_BEQ, K_J, K_ILL, K_RBAD: return 3;
      K_LW:                      return 5;
      default:                   return trap ? 5 : 4;
    endcase
  endfunction

  // Expected outputs on cycle c (0 = FETCH) of instruction kind k
  function automatic logic [18:0] expect_out(input kind_t k, input int c, input logic z,
                                             input bit trap);
    logic [18:0] v;
    v = '0;
    if (c == 0) v = pack(3'b000,0,2'b00,1,2'b00,1,1,0,0,0,0,0,0);
    else if (c == 2) begin
      case (k)
        K_ADDU:  v = pack(3'b000,0,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
        K_SUBU:  v = pack(3'b001,0,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
        K_SLT:   v = pack(3'b011,0,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
        K_ADDIU: v = pack(3'b000,1,2'b01,0,2'b00,0,0,0,0,0,0,0,0);
        K_ORI:   v = pack(3'b010,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0);
        K_LUI:   v = pack(3'b010,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0);
        K_ADDI:  v = pack(3'b100,1,2'b01,0,2'b00,0,0,0,0,0,0,0,0);
        K_LW, K_SW: v = pack(3'b000,1,2'b01,0,2'b00,0,0,0,0,0,0,0,0);
        K_BEQ:   v = pack(3'b001,0,2'b00,z,2'b01,0,0,0,0,0,0,1,0);
        K_J:     v = pack(3'b000,0,2'b00,1,2'b10,0,0,0,0,0,0,1,0);
        default: v = pack(3'b000,0,2'b00,0,2'b00,0,0,0,0,0,0,1,1);
      endcase
    end else if (c == 3) begin
      case (k)
        K_ADDU, K_SUBU, K_SLT: v = pack(3'b000,0,2'b00,0,2'b00,0,0,0,1,1,0,1,0);
        K_ADDIU, K_ORI, K_LUI, K_ADDI:
          v = trap ? '0 : pack(3'b000,0,2'b00,0,2'b00,0,0,0,1,0,0,1,0);
        K_LW:    v = pack(3'b000,0,2'b00,0,2'b00,0,1,0,0,0,0,0,0);
        K_SW:    v = pack(3'b000,0,2'b00,0,2'b00,0,0,1,0,0,0,1,0);
        default: v = '0;
      endcase
    end else if (c == 4) begin
      if (k == K_LW) v = pack(3'b000,0,2'b00,0,2'b00,0,0,0,1,0,1,1,0);
      else if (trap) v = pack(3'b000,0,2'b00,0,2'b00,0,0,0,0,0,0,1,1);
    end
    return v;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b001001, 6'b001101, 6'b001111, 6'b001000,
                      6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction

  task automatic set_ir(input kind_t k);
    logic [5:0] r;
    funct = 6'($urandom);
    case (k)
      K_ADDU:  begin opcode = 6'b000000; funct = 6'b100001; end
      K_SUBU:  begin opcode = 6'b000000; funct = 6'b100011; end
      K_SLT:   begin opcode = 6'b000000; funct = 6'b101010; end
      K_RBAD: begin
        opcode = 6'b000000;
        r = 6'($urandom);
        while (r inside {6'b100001, 6'b100011, 6'b101010}) r = 6'($urandom);
        funct = r;
      end
      K_ADDIU: opcode = 6'b001001;
      K_ORI:   opcode = 6'b001101;
      K_LUI:   opcode = 6'b001111;
      K_ADDI:  opcode = 6'b001000;
      K_LW:    opcode = 6'b100011;
      K_SW:    opcode = 6'b101011;
      K_BEQ:   opcode = 6'b000100;
      K_J:     opcode = 6'b000010;
      default: begin
        r = 6'($urandom);
        while (legal_op(r)) r = 6'($urandom);
        opcode = r;
      end
    endcase
  endtask

  // Run one instruction from FETCH; fmode 0 random flags, 1 force 0, 2 force 1.
  // stop_at < length aborts before checking that cycle (used for mid-instruction reset).
  task automatic run_instr(input kind_t k, input int fmode, input int stop_at,
                           input logic [5:0] force_op);
    bit trap;
    int len;
    trap = 1'b0;
    len  = instr_len(k, trap);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == stop_at) return;
      zero     = (fmode == 0) ? 1'($urandom) : (fmode == 2);
      overflow = (fmode == 0) ? 1'($urandom) : (fmode == 2);
      if (c == 0) begin
        set_ir(k);
        if (force_op != 6'b000000) opcode = force_op;
      end
      if (c >= 3) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      #1;
      check($sformatf("%s_c%0d", k.name(), c), obs, expect_out(k, c, zero, trap));
      if (c == 2 && k == K_ADDI && overflow && TRAP_EN) begin
        trap = 1'b1;
        len  = instr_len(k, trap);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", obs, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs, '0);

    // Directed cases
    run_instr(K_ADDU, 0, 99, 6'b000000);
    run_instr(K_LW,   0, 99, 6'b000000);
    run_instr(K_BEQ,  2, 99, 6'b000000);
    run_instr(K_BEQ,  1, 99, 6'b000000);
    run_instr(K_ADDI, 2, 99, 6'b000000);
    run_instr(K_ADDI, 1, 99, 6'b000000);
    run_instr(K_ILL,  0, 99, 6'b111111);
    run_instr(K_SW,   0, 99, 6'b000000);
    run_instr(K_J,    0, 99, 6'b000000);
    run_instr(K_RBAD, 0, 99, 6'b000000);

    // Reset held 3 cycles while in S_MRD of a lw
    run_instr(K_LW, 0, 3, 6'b000000);
    #2 rst_n = 1'b0;
    #1 check("reset_async_mrd", obs, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset_hold_%0d", i), obs, '0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_mid_reset", obs, '0);
    run_instr(K_ADDU, 0, 99, 6'b000000);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 12));
      run_instr(k, 0, 99, 6'b000000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
